term_char_write_ctrl: RTL and testbench

//  Accepts ASCII characters from the PIA display port (d + da strobe), filters and folds them to
//  the terminal's 6-bit character code, and waits for the cursor slot to pass the write point of
//  the recirculating character memory before issuing a one-cycle write (or CR request).

---
 rtl/term_char_write_ctrl.sv | 126 ++++++++++++
 tb/tb_term_char_write_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/term_char_write_ctrl.sv
// Terminal character write controller.
// Takes ASCII characters from the PIA display port on a rising da level, folds them to the
// terminal's 6-bit character code, and waits for the cursor slot to reach the write point of the
// recirculating character memory. It then issues a one-cycle write strobe, or a newline request
// for carriage return. The PIA handshake is held off (rda low) until da returns low.
//
// Ports:
//   cp_i          clock, all state changes on rising edge
//   mr_i          asynchronous active-high reset
//   d_i[6:0]      ASCII character from the PIA
//   da_i          data-available level from the PIA, synchronous to cp_i
//   cursor_win_i  one-cycle pulse when the cursor slot is at the write point
//   clr_req_i     screen-clear request, aborts any pending character
//   rda_o         ready-for-data to the PIA, high only when idle
//   wr_en_o       one-cycle character-memory write strobe
//   wr_data_o     6-bit character code, valid with wr_en_o and held otherwise
//   cr_pulse_o    one-cycle newline request to the cursor logic
//   busy_o        high while waiting for the window or writing
// All outputs are registered.

module term_char_write_ctrl #(
  parameter logic [6:0] CrCode  = 7'h0D,
  parameter logic [6:0] DelCode = 7'h7F
) (
  input  logic       cp_i,
  input  logic       mr_i,
  input  logic [6:0] d_i,
  input  logic       da_i,
  input  logic       cursor_win_i,
  input  logic       clr_req_i,
  output logic       rda_o,
  output logic       wr_en_o,
  output logic [5:0] wr_data_o,
  output logic       cr_pulse_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {StIdle, StWaitWin, StWrite, StAck} state_e;

  state_e     state_q, state_d;
  logic       da_q;
  logic [5:0] code_q, code_d;
  logic       is_cr_q, is_cr_d;
  logic       rda_q, rda_d;
  logic       wr_en_q, wr_en_d;
  logic       cr_q, cr_d;
  logic       busy_q, busy_d;
  logic [5:0] wr_data_q, wr_data_d;

  logic       da_rise;
  logic       in_is_cr;
  logic       in_discard;
  logic [5:0] in_code;

  assign da_rise    = da_i & ~da_q;
  assign in_is_cr   = (d_i == CrCode);
  assign in_discard = !in_is_cr && ((d_i < 7'h20) || (d_i == DelCode));
  // Subtracting 0x20 from a lower-case code (bits 6:5 = 11) only clears bit 5 of the kept 6 bits.
  assign in_code    = {d_i[5] & ~d_i[6], d_i[4:0]};

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    is_cr_d = is_cr_q;
    if (clr_req_i) begin
      // Clear wins over everything, including a da rise in the same cycle.
      state_d = da_i ? StAck : StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (da_rise) begin
            if (in_discard) begin
              state_d = StAck;
            end else begin
              state_d = StWaitWin;
              code_d  = in_code;
              is_cr_d = in_is_cr;
            end
          end
        end
        StWaitWin: if (cursor_win_i) state_d = StWrite;
        StWrite:   state_d = StAck;
        StAck:     if (!da_i) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    rda_d     = (state_d == StIdle);
    busy_d    = (state_d == StWaitWin) || (state_d == StWrite);
    wr_en_d   = (state_d == StWrite) && !is_cr_d;
    cr_d      = (state_d == StWrite) && is_cr_d;
    wr_data_d = wr_en_d ? code_d : wr_data_q;
  end

  always_ff @(posedge cp_i or posedge mr_i) begin
    if (mr_i) begin
      state_q   <= StIdle;
      da_q      <= 1'b0;
      code_q    <= 6'h00;
      is_cr_q   <= 1'b0;
      rda_q     <= 1'b1;
      wr_en_q   <= 1'b0;
      cr_q      <= 1'b0;
      busy_q    <= 1'b0;
      wr_data_q <= 6'h00;
    end else begin
      state_q   <= state_d;
      da_q      <= da_i;
      code_q    <= code_d;
      is_cr_q   <= is_cr_d;
      rda_q     <= rda_d;
      wr_en_q   <= wr_en_d;
      cr_q      <= cr_d;
      busy_q    <= busy_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign rda_o      = rda_q;
  assign wr_en_o    = wr_en_q;
  assign cr_pulse_o = cr_q;
  assign busy_o     = busy_q;
  assign wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_term_char_write_ctrl.sv
// Directed bench for term_char_write_ctrl.
module tb_term_char_write_ctrl;

  logic       cp;
  logic       mr;
  logic [6:0] d;
  logic       da;
  logic       cursor_win;
  logic       clr_req;
  logic       rda;
  logic       wr_en;
  logic [5:0] wr_data;
  logic       cr_pulse;
  logic       busy;

  int tests = 0;
  int fails = 0;

  term_char_write_ctrl dut (
    .cp_i         (cp),
    .mr_i         (mr),
    .d_i          (d),
    .da_i         (da),
    .cursor_win_i (cursor_win),
    .clr_req_i    (clr_req),
    .rda_o        (rda),
    .wr_en_o      (wr_en),
    .wr_data_o    (wr_data),
    .cr_pulse_o   (cr_pulse),
    .busy_o       (busy)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge cp);
    #1;
  endtask

  // Full printable or CR transaction with the window arriving after a few idle waits.
  task automatic send(input logic [6:0] c, input logic [5:0] exp_code, input logic cr,
                      input logic [5:0] exp_held);
    d  = c;
    da = 1'b1;
    step();
    chk("cap_rda", rda, 0);
    chk("cap_busy", busy, 1);
    repeat (3) step();
    chk("wait_nowr", wr_en | cr_pulse, 0);
    cursor_win = 1'b1;
    step();
    cursor_win = 1'b0;
    chk("win_wr_en", wr_en, !cr);
    chk("win_cr", cr_pulse, cr);
    chk("win_data", wr_data, cr ? exp_held : exp_code);
    step();
    chk("ack_wr_off", wr_en | cr_pulse, 0);
    chk("ack_rda", rda, 0);
    chk("ack_busy", busy, 0);
    step();
    chk("ack_hold", rda, 0);
    da = 1'b0;
    step();
    chk("idle_rda", rda, 1);
  endtask

  initial begin
    mr = 1'b1; d = 7'h00; da = 1'b0; cursor_win = 1'b0; clr_req = 1'b0;
    #3;
    chk("rst_rda", rda, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_cr", cr_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", wr_data, 0);
    @(negedge cp);
    mr = 1'b0;
    repeat (2) step();
    chk("idle_rda0", rda, 1);

    // Basic print and code folding.
    send(7'h41, 6'h01, 1'b0, 6'h00);
    send(7'h61, 6'h01, 1'b0, 6'h01);
    send(7'h3F, 6'h3F, 1'b0, 6'h01);
    send(7'h7B, 6'h1B, 1'b0, 6'h3F);
    // CR: newline pulse only, wr_data keeps the last printed code.
    send(7'h0D, 6'h00, 1'b1, 6'h1B);
    chk("cr_held", wr_data, 6'h1B);

    // Discarded characters: no write, straight to ACK.
    d = 7'h07; da = 1'b1;
    step();
    chk("bel_rda", rda, 0);
    chk("bel_busy", busy, 0);
    cursor_win = 1'b1;
    step();
    cursor_win = 1'b0;
    chk("bel_nowr", wr_en | cr_pulse, 0);
    da = 1'b0;
    step();
    chk("bel_rda1", rda, 1);
    d = 7'h7F; da = 1'b1;
    step();
    chk("del_busy", busy, 0);
    cursor_win = 1'b1;
    step();
    cursor_win = 1'b0;
    chk("del_nowr", wr_en | cr_pulse, 0);
    chk("del_rda", rda, 0);
    da = 1'b0;
    step();
    chk("del_rda1", rda, 1);

    // Window pulse in the capture cycle is ignored.
    d = 7'h5A; da = 1'b1; cursor_win = 1'b1;
    step();
    cursor_win = 1'b0;
    chk("coin_busy", busy, 1);
    step();
    chk("coin_nowr", wr_en, 0);
    cursor_win = 1'b1;
    step();
    cursor_win = 1'b0;
    chk("coin_wr", wr_en, 1);
    chk("coin_data", wr_data, 6'h1A);
    da = 1'b0;
    step();
    chk("coin_ack", rda, 0);
    step();
    chk("coin_idle", rda, 1);

    // Clear while waiting, da still high.
    d = 7'h42; da = 1'b1;
    step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_rda", rda, 0);
    cursor_win = 1'b1;
    step();
    cursor_win = 1'b0;
    chk("clr_nowr", wr_en | cr_pulse, 0);
    step();
    chk("clr_rda_hold", rda, 0);
    da = 1'b0;
    step();
    chk("clr_rda1", rda, 1);

    // Clear coincident with da rise: no capture.
    d = 7'h43; da = 1'b1; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    chk("clrr_busy", busy, 0);
    chk("clrr_rda", rda, 0);
    cursor_win = 1'b1;
    step();
    cursor_win = 1'b0;
    chk("clrr_nowr", wr_en, 0);
    da = 1'b0;
    step();
    chk("clrr_rda1", rda, 1);

    // Asynchronous reset in the middle of a cycle while waiting.
    d = 7'h44; da = 1'b1;
    step();
    chk("mr_pre_busy", busy, 1);
    #2;
    mr = 1'b1;
    #1;
    chk("mr_rda", rda, 1);
    chk("mr_busy", busy, 0);
    chk("mr_wr", wr_en, 0);
    chk("mr_data", wr_data, 0);
    da = 1'b0;
    #1;
    mr = 1'b0;
    cursor_win = 1'b1;
    step();
    cursor_win = 1'b0;
    chk("mr_nowr", wr_en | cr_pulse, 0);
    chk("mr_idle", rda, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
